// File: rtl/router_pkg.sv
// Shared definitions for the router output buffers: data/depth defaults,
// header field positions and the stored entry layout.
package router_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 2;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_W    = 6;

    // Wide enough for the largest length (63) plus the parity byte.
    localparam int PKT_CNT_W    = 7;

    typedef struct packed {
        logic                  hdr_flag;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one
// asynchronous read port, no reset.
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/router_out_fifo.sv
// Per-destination output buffer: tags header bytes on write and tracks the
// remaining length of the packet being read out.
module router_out_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_active
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DATA_W-1:0]     r_data_out;
    logic [PKT_CNT_W-1:0]  r_pkt_cnt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_mem_wr;
    fifo_entry_t           w_wr_entry;
    fifo_entry_t           w_rd_entry;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                      (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_wr_acc = write_enb && !w_full;
    assign w_rd_acc = read_enb && !w_empty;
    // A flush discards a same-cycle write, including its storage update.
    assign w_mem_wr = w_wr_acc && !soft_reset;

    assign w_wr_entry.hdr_flag = lfd_state;
    assign w_wr_entry.data     = data_in;

    router_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock     (clock),
        .i_wr_en   (w_mem_wr),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_entry)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_data_out <= '0;
            r_pkt_cnt  <= '0;
        end else if (soft_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_data_out <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
                r_data_out <= w_rd_entry.data;
                // Header loads payload length plus one for the parity byte.
                if (w_rd_entry.hdr_flag) begin
                    r_pkt_cnt <= PKT_CNT_W'(w_rd_entry.data[HDR_LEN_LSB +: HDR_LEN_W])
                                 + PKT_CNT_W'(1);
                end else if (r_pkt_cnt != '0) begin
                    r_pkt_cnt <= r_pkt_cnt - PKT_CNT_W'(1);
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign full       = w_full;
    assign empty      = w_empty;
    assign pkt_active = (r_pkt_cnt != '0);

endmodule
